// File: rtl/gfx_bus_pkg.sv
// Shared definitions for the graphics bus device: FSM encoding, header layout, frame limits.
package gfx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WDATA    = 3'd1,
    ST_TURN_OUT = 3'd2,
    ST_RDATA    = 3'd3,
    ST_TURN_IN  = 3'd4
  } state_t;

  localparam int HDR_DIR_BIT = 7;
  localparam int HDR_LEN_MSB = 6;
  localparam int HDR_LEN_LSB = 0;
  localparam int MAX_LEN     = 128;
  localparam int CNT_W       = $clog2(MAX_LEN) + 1;

  // Header carries N-1 in its length field; return the true payload count N.
  function automatic logic [CNT_W-1:0] hdr_len(input logic [7:0] hdr);
    return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign pop_data  = r_mem[r_rptr];

  // Storage array, written at the tail pointer; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= push_data;
  end

  // Pointers wrap naturally; occupancy tracks push minus pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
    end
  end

endmodule

// File: rtl/gfx_bus_device.sv
// Host-side byte bus device: decodes write/read frames, buffers writes, streams reads.
module gfx_bus_device
  import gfx_bus_pkg::*;
#(
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gfx_hok,
  output logic       gfx_dok,
  output logic       gfx_irq,
  input  logic [7:0] gfx_dq_i,
  output logic [7:0] gfx_dq_o,
  output logic       gfx_dq_oe,
  output logic [7:0] wr_data,
  output logic       wr_last,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic       rd_start,
  output logic [7:0] rd_len,
  input  logic [7:0] rd_data,
  input  logic       rd_valid,
  output logic       rd_ready,
  input  logic       irq_in
);

  localparam int LVL_W  = $clog2(RX_DEPTH) + 1;
  localparam int FREE_W = LVL_W + 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] r_req_left;
  logic [CNT_W-1:0] r_rd_len;
  logic             r_dok;
  logic             w_dok_next;
  logic             r_oe;
  logic             w_oe_next;
  logic             r_rd_start;
  logic [7:0]       r_obuf;
  logic             r_obuf_valid;
  logic             w_obuf_valid_next;
  logic             r_irq;

  logic             w_beat;
  logic             w_hdr_read;
  logic             w_last_beat;
  logic [CNT_W-1:0] w_hdr_len;
  logic             w_push;
  logic [8:0]       w_push_data;
  logic             w_pop;
  logic [8:0]       w_pop_data;
  logic             w_full;
  logic             w_empty;
  logic [LVL_W-1:0] w_level;
  logic [FREE_W-1:0] w_level_next;
  logic             w_free_ok;
  logic             w_rd_load;

  assign w_beat      = gfx_hok && r_dok;
  assign w_hdr_len   = hdr_len(gfx_dq_i);
  assign w_hdr_read  = (r_state == ST_IDLE) && w_beat && gfx_dq_i[HDR_DIR_BIT];
  assign w_last_beat = (r_cnt == CNT_W'(1));

  assign w_push      = (r_state == ST_WDATA) && w_beat && !w_full;
  assign w_push_data = {gfx_dq_i, w_last_beat};
  assign wr_valid    = !w_empty;
  assign w_pop       = wr_valid && wr_ready;
  assign wr_data     = w_pop_data[8:1];
  assign wr_last     = w_pop_data[0];

  // Room must remain for one more byte the host may already have launched.
  assign w_level_next = FREE_W'(w_level) + FREE_W'(w_push) - FREE_W'(w_pop);
  assign w_free_ok    = (FREE_W'(RX_DEPTH) - w_level_next) >= FREE_W'(2);

  assign rd_ready  = (r_state == ST_RDATA) && (r_req_left != '0) && (!r_obuf_valid || w_beat);
  assign w_rd_load = rd_valid && rd_ready;

  assign gfx_dok   = r_dok;
  assign gfx_dq_oe = r_oe;
  assign gfx_dq_o  = r_obuf;
  assign gfx_irq   = r_irq;
  assign rd_start  = r_rd_start;
  assign rd_len    = r_rd_len;

  sync_fifo #(
    .WIDTH (9),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty),
    .level     (w_level)
  );

  // Next-state, byte counter and registered bus handshake/enable values.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_dok_next        = 1'b0;
    w_oe_next         = 1'b0;
    w_obuf_valid_next = r_obuf_valid;

    case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          w_cnt_next   = w_hdr_len;
          w_state_next = gfx_dq_i[HDR_DIR_BIT] ? ST_TURN_OUT : ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (w_beat) begin
          w_cnt_next = r_cnt - CNT_W'(1);
          if (w_last_beat) w_state_next = ST_IDLE;
        end
      end
      ST_TURN_OUT: w_state_next = ST_RDATA;
      ST_RDATA: begin
        if (w_beat) begin
          w_cnt_next = r_cnt - CNT_W'(1);
          if (w_last_beat) w_state_next = ST_TURN_IN;
        end
      end
      ST_TURN_IN: w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase

    if (w_rd_load) begin
      w_obuf_valid_next = 1'b1;
    end else if ((r_state == ST_RDATA) && w_beat) begin
      w_obuf_valid_next = 1'b0;
    end

    case (w_state_next)
      ST_IDLE, ST_WDATA: w_dok_next = w_free_ok;
      ST_RDATA:          w_dok_next = w_obuf_valid_next;
      default:           w_dok_next = 1'b0;
    endcase

    w_oe_next = (w_state_next == ST_RDATA);
  end

  // FSM state, counter and bus-facing control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dok   <= 1'b0;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_dok   <= w_dok_next;
      r_oe    <= w_oe_next;
    end
  end

  // Read-side datapath: output byte register, request budget, frame info, irq stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_obuf       <= '0;
      r_obuf_valid <= 1'b0;
      r_req_left   <= '0;
      r_rd_len     <= '0;
      r_rd_start   <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_obuf_valid <= w_obuf_valid_next;
      r_rd_start   <= w_hdr_read;
      r_irq        <= irq_in;
      if (w_rd_load) r_obuf <= rd_data;
      if (w_hdr_read) begin
        r_req_left <= w_hdr_len;
        r_rd_len   <= w_hdr_len;
      end else if (w_rd_load) begin
        r_req_left <= r_req_left - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gfx_bus_device.sv
// Scoreboard bench for gfx_bus_device: directed frames, monitors compare bus and stream traffic.
module tb_gfx_bus_device;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       gfx_hok;
  logic       gfx_dok;
  logic       gfx_irq;
  logic [7:0] gfx_dq_i;
  logic [7:0] gfx_dq_o;
  logic       gfx_dq_oe;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       wr_valid;
  logic       wr_ready;
  logic       rd_start;
  logic [7:0] rd_len;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       irq_in;

  int nChecks = 0;
  int nFails  = 0;
  int hostBeats = 0;
  int rdReadyCycles = 0;
  int rdLoads = 0;
  int cyc = 0;

  logic [8:0] wrExpQ[$];
  logic [7:0] rdExpQ[$];
  logic [7:0] coreQ[$];
  logic [8:0] wrExp;
  logic [7:0] rdExp;
  logic       coreFire;

  gfx_bus_device #(.RX_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gfx_hok   (gfx_hok),
    .gfx_dok   (gfx_dok),
    .gfx_irq   (gfx_irq),
    .gfx_dq_i  (gfx_dq_i),
    .gfx_dq_o  (gfx_dq_o),
    .gfx_dq_oe (gfx_dq_oe),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_start  (rd_start),
    .rd_len    (rd_len),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .irq_in    (irq_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // Host presents one byte and holds it until a beat takes it.
  task automatic applyStimulus(input logic [7:0] b);
    bit done = 1'b0;
    gfx_hok  = 1'b1;
    gfx_dq_i = b;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (gfx_dok === 1'b1) done = 1'b1;
    end
    if (!done) begin
      reportTimeout("host_beat");
      return;
    end
    @(posedge clk);
    #1;
    hostBeats++;
  endtask

  task automatic waitRdDrain(input int remaining);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (rdExpQ.size() <= remaining) done = 1'b1;
    end
    if (!done) reportTimeout("rd_drain");
  endtask

  task automatic irqPulse();
    irq_in = 1'b1;
    checkOutput("irq_pre", gfx_irq, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("irq_high", gfx_irq, 1'b1);
    end
    irq_in = 1'b0;
    checkOutput("irq_hold", gfx_irq, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("irq_low", gfx_irq, 1'b0);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_dok", gfx_dok, 1'b0);
    checkOutput("rst_oe", gfx_dq_oe, 1'b0);
    checkOutput("rst_dq_o", gfx_dq_o, 8'h00);
    checkOutput("rst_irq", gfx_irq, 1'b0);
    checkOutput("rst_wr_valid", wr_valid, 1'b0);
    checkOutput("rst_rd_ready", rd_ready, 1'b0);
    checkOutput("rst_rd_start", rd_start, 1'b0);
    checkOutput("rst_rd_len", rd_len, 8'h00);
  endtask

  // Write-stream monitor: every core-side pop is compared with the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      if (wrExpQ.size() == 0) begin
        reportTimeout("wr_unexpected_byte");
      end else begin
        wrExp = wrExpQ.pop_front();
        checkOutput("wr_beat", {wr_data, wr_last}, wrExp);
      end
    end
  end

  // Read-bus monitor: every device-driven beat is compared with the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && gfx_hok && gfx_dok && gfx_dq_oe) begin
      if (rdExpQ.size() == 0) begin
        reportTimeout("rd_unexpected_beat");
      end else begin
        rdExp = rdExpQ.pop_front();
        checkOutput("rd_beat", gfx_dq_o, rdExp);
      end
    end
  end

  // Core read source: offers queued bytes and counts handshakes.
  initial begin
    rd_valid = 1'b0;
    rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      coreFire = rd_valid && rd_ready;
      if (rd_ready) rdReadyCycles++;
      @(posedge clk);
      #1;
      if (coreFire) begin
        void'(coreQ.pop_front());
        rdLoads++;
      end
      rd_valid = (coreQ.size() != 0);
      rd_data  = (coreQ.size() != 0) ? coreQ[0] : 8'h00;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c1;
    int c2;
    gfx_hok  = 1'b0;
    gfx_dq_i = 8'h00;
    wr_ready = 1'b0;
    irq_in   = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    checkResetValues();
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("dok_first_edge", gfx_dok, 1'b1);

    irqPulse();

    // Write N=3 followed immediately by read N=2
    wr_ready = 1'b1;
    wrExpQ.push_back({8'hA1, 1'b0});
    wrExpQ.push_back({8'hB2, 1'b0});
    wrExpQ.push_back({8'hC3, 1'b1});
    applyStimulus(8'h02);
    applyStimulus(8'hA1);
    applyStimulus(8'hB2);
    applyStimulus(8'hC3);
    c1 = cyc;

    coreQ.push_back(8'h5A);
    coreQ.push_back(8'h3C);
    coreQ.push_back(8'hEE);
    rdExpQ.push_back(8'h5A);
    rdExpQ.push_back(8'h3C);
    rdReadyCycles = 0;
    rdLoads = 0;
    applyStimulus(8'h81);
    c2 = cyc;
    checkOutput("idle_after_write", c2 - c1, 1);
    checkOutput("rd_start_pulse", rd_start, 1'b1);
    checkOutput("rd_len", rd_len, 8'd2);
    checkOutput("turn_out_oe", gfx_dq_oe, 1'b0);
    checkOutput("turn_out_dok", gfx_dok, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rd_start_once", rd_start, 1'b0);
    checkOutput("rdata_oe", gfx_dq_oe, 1'b1);
    waitRdDrain(0);
    checkOutput("turn_in_oe", gfx_dq_oe, 1'b0);
    checkOutput("turn_in_dok", gfx_dok, 1'b0);
    checkOutput("rd_len_held", rd_len, 8'd2);
    gfx_hok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rd_ready_cycles", rdReadyCycles, 2);
    checkOutput("rd_loads", rdLoads, 2);
    checkOutput("core_leftover", coreQ.size(), 1);
    coreQ.delete();

    // Read N=4 with a 5-cycle host stall and an irq pulse during RDATA
    coreQ.push_back(8'h11);
    coreQ.push_back(8'h22);
    coreQ.push_back(8'h33);
    coreQ.push_back(8'h44);
    rdExpQ.push_back(8'h11);
    rdExpQ.push_back(8'h22);
    rdExpQ.push_back(8'h33);
    rdExpQ.push_back(8'h44);
    applyStimulus(8'h83);
    checkOutput("rd_len_4", rd_len, 8'd4);
    waitRdDrain(3);
    gfx_hok = 1'b0;
    fork
      irqPulse();
      begin
        repeat (5) begin
          @(posedge clk);
          #1;
          checkOutput("stall_dq_o", gfx_dq_o, 8'h22);
          checkOutput("stall_dok", gfx_dok, 1'b1);
        end
      end
    join
    gfx_hok = 1'b1;
    waitRdDrain(0);
    gfx_hok = 1'b0;
    checkOutput("stall_turn_in_oe", gfx_dq_oe, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: 128-byte write with the core stalled at first
    wr_ready  = 1'b0;
    hostBeats = 0;
    for (int i = 0; i < 128; i++) wrExpQ.push_back({8'(i) ^ 8'h5A, i == 127});
    fork
      begin
        applyStimulus(8'h7F);
        for (int i = 0; i < 128; i++) applyStimulus(8'(i) ^ 8'h5A);
        gfx_hok = 1'b0;
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        checkOutput("bp_accepted", hostBeats - 1, 3);
        checkOutput("bp_dok_low", gfx_dok, 1'b0);
        checkOutput("bp_queue_intact", wrExpQ.size(), 128);
        wr_ready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && wrExpQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("bp_all_delivered", wrExpQ.size(), 0);

    // Reset in the middle of a 5-byte write
    wr_ready = 1'b0;
    applyStimulus(8'h04);
    applyStimulus(8'h71);
    applyStimulus(8'h72);
    gfx_hok = 1'b0;
    checkOutput("wr_valid_before_reset", wr_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkResetValues();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("dok_after_midframe_reset", gfx_dok, 1'b1);
    wr_ready = 1'b1;
    wrExpQ.push_back({8'h11, 1'b1});
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    gfx_hok = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("post_reset_delivered", wrExpQ.size(), 0);
    checkOutput("rd_queue_empty", rdExpQ.size(), 0);
    checkOutput("no_stray_wr_valid", wr_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/gfx_bus_device.md
GFX_BUS_DEVICE -- requirements
Module: gfx_bus_device

Interface
REQ-001 Parameter RX_DEPTH, default 4, sets receive FIFO entries; legal values are powers of two, 4 or more.
REQ-002 clk  input  1  gfx_clk from host, 25.2 MHz; sole clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 gfx_hok  input  1  host OK: host has a byte (write phase) or can take a byte (read phase).
REQ-005 gfx_dok  output  1  device OK: device can take a byte (write phase) or has a byte (read phase); registered.
REQ-006 gfx_irq  output  1  interrupt to host; registered.
REQ-007 gfx_dq_i  input  8  bus value sampled from pads.
REQ-008 gfx_dq_o  output  8  bus drive value; registered.
REQ-009 gfx_dq_oe  output  1  pad output enable, 1 = device drives; registered.
REQ-010 wr_data  output  8  received payload byte to core.
REQ-011 wr_last  output  1  marks the final byte of a write frame.
REQ-012 wr_valid / wr_ready  output / input  1 each  core-side write stream handshake.
REQ-013 rd_start  output  1  one-cycle pulse when a read header is accepted.
REQ-014 rd_len  output  8  read byte count, 1..128; held from rd_start until the frame ends.
REQ-015 rd_data  input  8  core read byte.
REQ-016 rd_valid / rd_ready  input / output  1 each  core-side read stream handshake.
REQ-017 irq_in  input  1  level interrupt request from core.

Function
REQ-018 A bus beat occurs on any rising clk where gfx_hok and gfx_dok are both 1; no other edge transfers data.
REQ-019 Frame format: header byte, bit 7 = direction (0 write, 1 read), bits 6:0 = N-1, giving N = 1..128 payload bytes.
REQ-020 FSM states: IDLE, WDATA, TURN_OUT, RDATA, TURN_IN.
REQ-021 IDLE: gfx_dq_oe=0 and gfx_dok=1; a beat captures the header and loads the byte counter with N.
   - Direction 0: next state WDATA.
   - Direction 1: next state TURN_OUT and rd_start pulses.
REQ-022 WDATA: each beat pushes {gfx_dq_i, counter==1} into the RX FIFO and decrements the counter; the beat at counter==1 returns the FSM to IDLE.
REQ-023 gfx_dok in IDLE and WDATA is registered: 1 only if the RX FIFO will have 2 or more free entries after the current cycle's push and pop; the FIFO never overflows even when the host samples gfx_dok one cycle late.
REQ-024 The RX FIFO drives wr_data, wr_last and wr_valid directly; a pop occurs when wr_valid and wr_ready are both 1; push and pop in the same cycle are both honoured.
REQ-025 TURN_OUT lasts exactly one cycle with gfx_dok=0; gfx_dq_oe rises on entry to RDATA.
REQ-026 RDATA: a one-byte output register feeds gfx_dq_o; gfx_dok=1 exactly when the register holds valid data.
   - rd_ready is 1 when the register is empty, or when a beat consumes it this cycle.
   - rd_valid and rd_ready both 1 loads the register, giving zero-bubble streaming.
REQ-027 Each RDATA beat decrements the counter; the beat at counter==1 clears gfx_dok and gfx_dq_oe and moves to TURN_IN.
REQ-028 The device never requests more than rd_len bytes from the core (rd_ready=0 once rd_len bytes have been loaded).
REQ-029 TURN_IN lasts one cycle with gfx_dok=0 and gfx_dq_oe=0, then goes to IDLE; the device never drives the bus in the cycle the host resumes driving.
REQ-030 gfx_irq equals irq_in delayed by one register stage, independent of FSM state.
REQ-031 gfx_hok=0 in any state only stalls; the counter and data are held indefinitely.

Reset
REQ-032 On rst_n=0, asynchronously:
   - FSM returns to IDLE; the RX FIFO is emptied; the counter is cleared.
   - gfx_dok=0, gfx_dq_oe=0, gfx_dq_o=0, gfx_irq=0, wr_valid=0, rd_ready=0, rd_start=0, rd_len=0.
REQ-033 Reset during WDATA or RDATA abandons the frame without emitting wr_last; gfx_dok rises to 1 on the first clk edge after rst_n deasserts.

Structure
REQ-034 A shared package gfx_bus_pkg holds the FSM state encoding, the header bit positions (DIR bit 7, LEN bits 6:0) and MAX_LEN=128.
REQ-035 The RX FIFO is a sub-module sync_fifo (parameters WIDTH=9, DEPTH=RX_DEPTH) with push/pop/full/empty/level; all other logic is inline.

Verification
REQ-036 Write N=3:
   - Stimulus: header 0x02, then 0xA1 0xB2 0xC3, with gfx_hok held high and wr_ready=1.
   - Response: wr stream carries A1, B2, C3+last; FSM is back in IDLE on the cycle after the 4th beat.
REQ-037 Backpressure, RX_DEPTH=4:
   - Stimulus: header 0x7F, gfx_hok always 1, wr_ready=0.
   - Response: gfx_dok falls before more than 4 bytes are accepted; no byte is lost.
   - Then wr_ready=1: all 128 bytes are delivered in order, with last on byte 128.
REQ-038 Read N=2:
   - Stimulus: header 0x81; core supplies 0x5A, 0x3C; host keeps gfx_hok=1.
   - Response: rd_start pulses with rd_len=2; one TURN_OUT cycle with gfx_dq_oe=0.
   - Response: beats 5A then 3C; gfx_dq_oe=0 during TURN_IN; rd_ready never high a third time.
REQ-039 Host stall: during a read of N=4, gfx_hok=0 for 5 cycles mid-frame -> gfx_dq_o holds the same byte and gfx_dok stays 1 throughout.
REQ-040 Reset mid-frame:
   - Stimulus: rst_n pulled low after 2 of 5 write bytes.
   - Response: all outputs at reset values within the same cycle; wr_valid=0.
   - Response: next header 0x00 + 0x11 yields a single byte with last.
REQ-041 IRQ: irq_in toggles 0->1->0 with a 3-cycle high -> gfx_irq mirrors it with exactly one cycle of delay, in every FSM state.
